// File: rtl/wbm_pkg.sv
// Shared constants for the Wishbone command master: FSM state encoding and byte-lane helper.
package wbm_pkg;

  typedef logic [1:0] wbm_state_t;

  localparam wbm_state_t ST_IDLE = 2'd0;
  localparam wbm_state_t ST_BUS  = 2'd1;
  localparam wbm_state_t ST_RESP = 2'd2;

  localparam int unsigned WBM_DW_DEF    = 32;
  localparam int unsigned WBM_LANES_DEF = WBM_DW_DEF / 8;

  function automatic int unsigned wbm_lanes(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wbm_watchdog.sv
// Bus-cycle watchdog: down-counter reloaded while idle, flags expiry on its TIMEOUT-th enabled cycle.
module wbm_watchdog #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      cnt_q <= LOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count reached while the bus cycle is still open.
  assign expired_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one queued command -> one single-beat WB cycle -> one response.
// Optional ack watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_cmd_master
  import wbm_pkg::*;
#(
  parameter  int unsigned AW      = 32,
  parameter  int unsigned DW      = WBM_DW_DEF,
  parameter  int unsigned TIMEOUT = 255,
  parameter  int unsigned TW      = 8,
  localparam int unsigned SW      = wbm_lanes(DW)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_adr_i,
  input  logic [DW-1:0] cmd_dat_i,
  input  logic [SW-1:0] cmd_sel_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_dat_o,
  output logic          rsp_err_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [SW-1:0] wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic [DW-1:0] wbm_dat_i,
  input  logic          wbm_ack_i,
  output logic          busy_o
);

  wbm_state_t    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          timeout_w;

`ifdef WBM_TIMEOUT_EN
  wbm_watchdog #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .clr_i     (state_q != ST_BUS),
    .en_i      (state_q == ST_BUS),
    .expired_o (timeout_w)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT < (1 << TW));
  assign timeout_w  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d   = ST_BUS;
          we_d      = cmd_we_i;
          adr_d     = cmd_adr_i;
          dat_d     = cmd_dat_i;
          sel_d     = cmd_sel_i;
          rsp_dat_d = '0;
          rsp_err_d = 1'b0;
        end
      end
      ST_BUS: begin
        // Ack takes priority over a watchdog expiry on the same edge.
        if (wbm_ack_i) begin
          state_d   = ST_RESP;
          rsp_dat_d = we_q ? '0 : wbm_dat_i;
          rsp_err_d = 1'b0;
        end else if (timeout_w) begin
          state_d   = ST_RESP;
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign wbm_cyc_o   = (state_q == ST_BUS);
  assign wbm_stb_o   = (state_q == ST_BUS);
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; expected responses queued at command time, checked on rsp handshake.
module tb_wb_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [AW-1:0] cmd_adr_i = '0;
  logic [DW-1:0] cmd_dat_i = '0;
  logic [SW-1:0] cmd_sel_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_dat_o;
  logic          rsp_err_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [SW-1:0] wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [DW-1:0] wbm_dat_o;
  logic [DW-1:0] wbm_dat_i = '0;
  logic          wbm_ack_i = 1'b0;
  logic          busy_o;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cmd_master #(
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (4),
    .TW      (8)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_we_i    (cmd_we_i),
    .cmd_adr_i   (cmd_adr_i),
    .cmd_dat_i   (cmd_dat_i),
    .cmd_sel_i   (cmd_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_ack_i   (wbm_ack_i),
    .busy_o      (busy_o)
  );

  task automatic tick();
    @(negedge wb_clk_i);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, presents one command for one accepted edge; returns in BUS.
  task automatic send(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel, input logic push, input logic e_err,
                      input logic [DW-1:0] e_dat);
    int n = 0;
    while (!cmd_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    cmd_valid_i = 1'b1;
    if (push) sb.push_back('{err: e_err, dat: e_dat});
    tick();
    cmd_valid_i = 1'b0;
    cmd_dat_i   = 32'hFFFF_FFFF;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int   n = 0;
    exp_t e;
    while (!rsp_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_valid"}, rsp_valid_o, 1);
    e = (sb.size() != 0) ? sb.pop_front() : '{err: 1'bx, dat: 'x};
    chk({tag, "_rsp_dat"}, rsp_dat_o, e.dat);
    chk({tag, "_rsp_err"}, rsp_err_o, e.err);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, rsp_valid_o, 1);
      chk({tag, "_hold_dat"}, rsp_dat_o, e.dat);
      chk({tag, "_hold_err"}, rsp_err_o, e.err);
      chk({tag, "_hold_ready"}, cmd_ready_o, 0);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid_o, 0);
    chk({tag, "_ready_back"}, cmd_ready_o, 1);
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  initial begin
    int cnt;

    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_outputs", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_dat_o, rsp_err_o}, 0);
    wb_rst_ni = 1'b1;
    tick();

    // Write with ack in the first bus cycle
    send(1'b1, 32'h3000_0000, 32'h0000_00A5, 4'b0001, 1'b1, 1'b0, 32'h0);
    chk("wr_cyc", wbm_cyc_o, 1);
    chk("wr_stb", wbm_stb_o, 1);
    chk("wr_we", wbm_we_o, 1);
    chk("wr_adr", wbm_adr_o, 32'h3000_0000);
    chk("wr_dat", wbm_dat_o, 32'h0000_00A5);
    chk("wr_sel", wbm_sel_o, 4'b0001);
    chk("wr_ready_low", cmd_ready_o, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_F00D;
    tick();
    wbm_ack_i = 1'b0;
    chk("wr_cyc_drop", wbm_cyc_o, 0);
    chk("wr_stb_drop", wbm_stb_o, 0);
    get_rsp("wr", 0);

    // Read with three wait states
    send(1'b0, 32'h3000_0004, 32'h0, 4'b1111, 1'b1, 1'b0, 32'h1234_5678);
    chk("rd_we", wbm_we_o, 0);
    chk("rd_sel", wbm_sel_o, 4'b1111);
    chk("rd_adr", wbm_adr_o, 32'h3000_0004);
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_cyc", wbm_cyc_o, 1);
      chk("rd_wait_ready", cmd_ready_o, 0);
      chk("rd_wait_no_rsp", rsp_valid_o, 0);
      tick();
    end
    chk("rd_last_cyc", wbm_cyc_o, 1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h1234_5678;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;
    chk("rd_cyc_drop", wbm_cyc_o, 0);
    get_rsp("rd", 0);

    // Read with partial byte enables; response stalled 5 cycles, stray ack in RESP
    send(1'b0, 32'h3000_0010, 32'h0, 4'b0110, 1'b1, 1'b0, 32'h00AB_CD00);
    chk("rd2_sel", wbm_sel_o, 4'b0110);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h00AB_CD00;
    tick();
    wbm_dat_i = 32'h5555_5555;
    get_rsp("stall", 5);
    wbm_ack_i = 1'b0;

    // Spurious ack while idle
    wbm_ack_i = 1'b1;
    tick();
    tick();
    wbm_ack_i = 1'b0;
    chk("spur_busy", busy_o, 0);
    chk("spur_rsp", rsp_valid_o, 0);
    chk("spur_cyc", wbm_cyc_o, 0);
    chk("spur_ready", cmd_ready_o, 1);

    // Reset during a bus cycle
    send(1'b1, 32'h3000_0020, 32'h0000_0077, 4'b1111, 1'b0, 1'b0, 32'h0);
    chk("rst_bus_cyc_pre", wbm_cyc_o, 1);
    wb_rst_ni = 1'b0;
    tick();
    chk("rst_bus_cyc", wbm_cyc_o, 0);
    chk("rst_bus_stb", wbm_stb_o, 0);
    chk("rst_bus_rsp", rsp_valid_o, 0);
    chk("rst_bus_ready", cmd_ready_o, 1);
    wb_rst_ni = 1'b1;
    tick();
    tick();
    chk("rst_bus_no_rsp", rsp_valid_o, 0);
    chk("rst_bus_idle", busy_o, 0);

`ifdef WBM_TIMEOUT_EN
    // No ack: cycle must be dropped after exactly 4 bus cycles with err
    send(1'b1, 32'h3000_0030, 32'h0000_0011, 4'b0011, 1'b1, 1'b1, 32'h0);
    cnt = 0;
    while (wbm_cyc_o && cnt < 20) begin
      cnt++;
      tick();
    end
    chk("to_cycles", cnt, 4);
    get_rsp("to", 2);

    // Ack on the expiry edge wins
    send(1'b0, 32'h3000_0034, 32'h0, 4'b1111, 1'b1, 1'b0, 32'h0BAD_F00D);
    tick();
    tick();
    tick();
    chk("to_race_cyc", wbm_cyc_o, 1);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0BAD_F00D;
    tick();
    wbm_ack_i = 1'b0;
    get_rsp("to_race", 0);
`else
    // Without the watchdog the bus cycle stays open indefinitely
    send(1'b0, 32'h3000_0030, 32'h0, 4'b1111, 1'b1, 1'b0, 32'h0000_4242);
    cnt = 0;
    while (wbm_cyc_o && cnt < 300) begin
      cnt++;
      tick();
    end
    chk("no_to_cycles", cnt, 300);
    chk("no_to_rsp", rsp_valid_o, 0);
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h0000_4242;
    tick();
    wbm_ack_i = 1'b0;
    get_rsp("no_to", 0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
